gpu_fill_rect: RTL and testbench
================================

GPU_FILL_RECT -- requirements
Module: gpu_fill_rect

Interface
REQ-001 Parameter WIDTH_BITS, default 10, width of every x coordinate.
REQ-002 Parameter HEIGHT_BITS, default 9, width of every y coordinate.
REQ-003 Clocking: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 n_rst  input  1  asynchronous active-low reset.
REQ-006 x1_i  input  WIDTH_BITS  first corner x.
REQ-007 y1_i  input  HEIGHT_BITS  first corner y.
REQ-008 x2_i  input  WIDTH_BITS  opposite corner x.
REQ-009 y2_i  input  HEIGHT_BITS  opposite corner y.
REQ-010 start_i  input  1  request to fill the rectangle given by the corner inputs.
REQ-011 x_o  output  WIDTH_BITS  current pixel x.
REQ-012 y_o  output  HEIGHT_BITS  current pixel y.
REQ-013 busy_o  output  1  high exactly on cycles where x_o/y_o is a valid pixel of the rectangle.
REQ-014 done_o  output  1  one-cycle completion pulse.

Function
REQ-015 The FSM SHALL have the states IDLE, FILL and DONE.
REQ-016 In IDLE, start_i sampled high SHALL latch the corners and enter FILL on the next edge.
- Latched xmin/xmax = min/max(x1_i, x2_i).
- Latched ymin/ymax = min/max(y1_i, y2_i).
- Unequal corners are swapped, so either corner order gives the same rectangle.
REQ-017 On the first FILL cycle, which is the cycle after start_i is sampled, the block SHALL drive x_o=xmin, y_o=ymin and busy_o=1.
REQ-018 Scan order in FILL SHALL be raster, one pixel per clock, with x as the inner loop.
- x increments from xmin to xmax inclusive.
- Then x returns to xmin and y increments, up to ymax inclusive.
REQ-019 After the pixel (xmax,ymax) the FSM SHALL enter DONE for exactly one cycle.
- done_o=1 and busy_o=0.
- x_o/y_o hold the last pixel.
- The FSM then returns to IDLE.
REQ-020 A FILL pass SHALL emit exactly (xmax-xmin+1)*(ymax-ymin+1) busy cycles, each pixel exactly once, none outside the rectangle.
REQ-021 A degenerate rectangle SHALL be handled as follows.
- x1=x2 and y1=y2: exactly one busy cycle, then done_o.
- Single row or single column: a line of pixels.
REQ-022 start_i and all corner inputs SHALL be ignored in FILL and DONE; changing corners mid-fill SHALL NOT affect the current pass.
REQ-023 start_i is level-sensitive in IDLE: if held high continuously, a new pass SHALL begin on the cycle after DONE.
REQ-024 Counters SHALL be compared for equality against the latched maxima, never relying on overflow.
- Rectangles touching 2^WIDTH_BITS-1 or 2^HEIGHT_BITS-1 terminate correctly without wrap-around.
REQ-025 In IDLE the block SHALL drive busy_o=0 and done_o=0; x_o/y_o hold their last values.
REQ-026 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-027 Asserting n_rst low SHALL immediately force IDLE, with x_o=0, y_o=0, busy_o=0, done_o=0 and latched corners cleared.
REQ-028 Reset asserted mid-fill SHALL abort the pass with no done_o pulse.
- After release, the block waits in IDLE for start_i.

Verification
REQ-029 Corners (0,0)-(5,6), start_i pulsed one cycle:
- 42 busy cycles in order (0,0),(1,0)..(5,0),(0,1)..(5,6).
- Then a single done_o cycle.
REQ-030 Corners (5,6)-(0,0): the pixel sequence and count are identical to REQ-029.
REQ-031 Corners (3,4)-(3,4):
- One busy cycle at (3,4).
- done_o on the next cycle.
- Then IDLE with busy_o=0.
REQ-032 start_i held high for 50 cycles with corners (0,0)-(1,1):
- Repeated passes of 4 busy cycles and 1 done_o cycle.
- Each pass starts on the cycle after DONE.
REQ-033 n_rst pulsed low after 10 pixels of the REQ-029 fill:
- Outputs go to 0 immediately.
- No done_o pulse.
- A new start_i restarts the fill at (0,0).
REQ-034 Corners (2^WIDTH_BITS-2, 0)-(2^WIDTH_BITS-1, 1): exactly 4 pixels, with no x wrap to 0.

Source files
------------

// File: rtl/gpu_fill_rect.sv
// Rectangle fill scanner: latches two corners and walks every pixel inside them in raster
// order, one pixel per clock, then pulses done_o for a single cycle.
module gpu_fill_rect #(
    parameter int unsigned WIDTH_BITS  = 10,
    parameter int unsigned HEIGHT_BITS = 9
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic [WIDTH_BITS-1:0]  x1_i,
    input  logic [HEIGHT_BITS-1:0] y1_i,
    input  logic [WIDTH_BITS-1:0]  x2_i,
    input  logic [HEIGHT_BITS-1:0] y2_i,
    input  logic                   start_i,
    output logic [WIDTH_BITS-1:0]  x_o,
    output logic [HEIGHT_BITS-1:0] y_o,
    output logic                   busy_o,
    output logic                   done_o
);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH_BITS-1:0]  xmin_q, xmin_d, xmax_q, xmax_d, x_q, x_d;
    logic [HEIGHT_BITS-1:0] ymin_q, ymin_d, ymax_q, ymax_d, y_q, y_d;
    logic                   busy_q, busy_d, done_q, done_d;

    logic [WIDTH_BITS-1:0]  in_xmin, in_xmax;
    logic [HEIGHT_BITS-1:0] in_ymin, in_ymax;

    // Corner ordering, so either corner pair describes the same rectangle.
    always_comb begin
        in_xmin = (x1_i < x2_i) ? x1_i : x2_i;
        in_xmax = (x1_i < x2_i) ? x2_i : x1_i;
        in_ymin = (y1_i < y2_i) ? y1_i : y2_i;
        in_ymax = (y1_i < y2_i) ? y2_i : y1_i;
    end

    always_comb begin
        state_d = state_q;
        xmin_d  = xmin_q;
        xmax_d  = xmax_q;
        ymin_d  = ymin_q;
        ymax_d  = ymax_q;
        x_d     = x_q;
        y_d     = y_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    xmin_d  = in_xmin;
                    xmax_d  = in_xmax;
                    ymin_d  = in_ymin;
                    ymax_d  = in_ymax;
                    x_d     = in_xmin;
                    y_d     = in_ymin;
                    busy_d  = 1'b1;
                    state_d = StFill;
                end
            end
            StFill: begin
                // Equality against the latched maxima keeps edge-touching rectangles from wrapping.
                if (x_q == xmax_q) begin
                    if (y_q == ymax_q) begin
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        x_d    = xmin_q;
                        y_d    = y_q + 1'b1;
                        busy_d = 1'b1;
                    end
                end else begin
                    x_d    = x_q + 1'b1;
                    busy_d = 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
            xmin_q  <= '0;
            xmax_q  <= '0;
            ymin_q  <= '0;
            ymax_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            xmin_q  <= xmin_d;
            xmax_q  <= xmax_d;
            ymin_q  <= ymin_d;
            ymax_q  <= ymax_d;
            x_q     <= x_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_gpu_fill_rect.sv
// Scoreboard bench for gpu_fill_rect: expected pixels are queued per pass and popped as the
// scanner emits them.
module tb_gpu_fill_rect;

    localparam int W = 10;
    localparam int H = 9;

    logic         clk;
    logic         n_rst;
    logic [W-1:0] x1_i, x2_i, x_o;
    logic [H-1:0] y1_i, y2_i, y_o;
    logic         start_i;
    logic         busy_o;
    logic         done_o;

    int checks   = 0;
    int failures = 0;

    logic [W+H-1:0] exp_q[$];

    gpu_fill_rect #(
        .WIDTH_BITS (W),
        .HEIGHT_BITS(H)
    ) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .x1_i   (x1_i),
        .y1_i   (y1_i),
        .x2_i   (x2_i),
        .y2_i   (y2_i),
        .start_i(start_i),
        .x_o    (x_o),
        .y_o    (y_o),
        .busy_o (busy_o),
        .done_o (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

    task automatic push_rect(input int x1, input int y1, input int x2, input int y2);
        int xa, xb, ya, yb;
        logic [W-1:0] xv;
        logic [H-1:0] yv;
        xa = (x1 < x2) ? x1 : x2;
        xb = (x1 < x2) ? x2 : x1;
        ya = (y1 < y2) ? y1 : y2;
        yb = (y1 < y2) ? y2 : y1;
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                xv = x[W-1:0];
                yv = y[H-1:0];
                exp_q.push_back({xv, yv});
            end
        end
    endtask

    // Leaves the bench on the negedge where the first pixel should be visible.
    task automatic start_pass(input int x1, input int y1, input int x2, input int y2,
                              input bit hold);
        @(negedge clk);
        x1_i    = x1[W-1:0];
        y1_i    = y1[H-1:0];
        x2_i    = x2[W-1:0];
        y2_i    = y2[H-1:0];
        start_i = 1'b1;
        @(negedge clk);
        if (!hold) start_i = 1'b0;
    endtask

    // Consumes one pass from the current negedge through the done_o cycle.
    task automatic drain(input string name, output int npix);
        int  budget;
        bit  finished;
        logic [W-1:0] ex;
        logic [H-1:0] ey;
        budget   = 5000;
        finished = 1'b0;
        npix     = 0;
        while (!finished && budget > 0) begin
            checks++;
            if (busy_o && done_o) begin
                failures++;
                $display("FAIL %s busy_and_done both high at pixel %0d", name, npix);
            end else if (busy_o) begin
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s extra_pixel got (%0d,%0d) expected none", name, x_o, y_o);
                end else begin
                    {ex, ey} = exp_q.pop_front();
                    if ({x_o, y_o} !== {ex, ey}) begin
                        failures++;
                        $display("FAIL %s pixel%0d got (%0d,%0d) expected (%0d,%0d)",
                                 name, npix, x_o, y_o, ex, ey);
                    end
                end
                npix++;
            end else if (done_o) begin
                finished = 1'b1;
                if (exp_q.size() != 0) begin
                    failures++;
                    $display("FAIL %s early_done got %0d pixels missing %0d", name, npix,
                             exp_q.size());
                end
            end else begin
                failures++;
                $display("FAIL %s gap busy=0 done=0 after %0d pixels expected busy or done",
                         name, npix);
            end
            @(negedge clk);
            budget--;
        end
        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL %s timeout no done_o after %0d pixels", name, npix);
        end
        exp_q.delete();
    endtask

    task automatic check_idle(input string name, input int ex, input int ey);
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || x_o !== ex[W-1:0] || y_o !== ey[H-1:0]) begin
            failures++;
            $display("FAIL %s idle got busy=%0b done=%0b xy=(%0d,%0d) expected 0 0 (%0d,%0d)",
                     name, busy_o, done_o, x_o, y_o, ex, ey);
        end
    endtask

    task automatic check_count(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s count got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        n_rst   = 1'b0;
        start_i = 1'b0;
        x1_i = '0; y1_i = '0; x2_i = '0; y2_i = '0;
        repeat (3) @(negedge clk);
        check_idle("reset_hold", 0, 0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle("reset_release", 0, 0);
    endtask

    task automatic test_basic();
        int n;
        push_rect(0, 0, 5, 6);
        start_pass(0, 0, 5, 6, 1'b0);
        drain("basic", n);
        check_count("basic", n, 42);
        check_idle("basic_after", 5, 6);
    endtask

    task automatic test_swapped();
        int n;
        push_rect(0, 0, 5, 6);
        start_pass(5, 6, 0, 0, 1'b0);
        drain("swapped", n);
        check_count("swapped", n, 42);
        check_idle("swapped_after", 5, 6);
    endtask

    task automatic test_single();
        int n;
        push_rect(3, 4, 3, 4);
        start_pass(3, 4, 3, 4, 1'b0);
        drain("single", n);
        check_count("single", n, 1);
        check_idle("single_after", 3, 4);
        @(negedge clk);
        check_idle("single_after2", 3, 4);
    endtask

    task automatic test_lines();
        int n;
        push_rect(7, 2, 12, 2);
        start_pass(12, 2, 7, 2, 1'b0);
        drain("row", n);
        check_count("row", n, 6);
        push_rect(9, 3, 9, 8);
        start_pass(9, 8, 9, 3, 1'b0);
        drain("column", n);
        check_count("column", n, 6);
    endtask

    task automatic test_midfill_change();
        int n;
        push_rect(1, 1, 3, 2);
        start_pass(3, 1, 1, 2, 1'b0);
        // New corners and a stray start pulse must not disturb the running pass.
        x1_i = 10'd100; y1_i = 9'd50; x2_i = 10'd200; y2_i = 9'd60;
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        @(negedge clk);
        // drain starts one pixel in; replace that pixel's slot by checking it here.
        drain_offset_check(n);
        check_count("midfill_change", n, 6);
    endtask

    task automatic drain_offset_check(output int n);
        logic [W-1:0] ex;
        logic [H-1:0] ey;
        {ex, ey} = exp_q.pop_front();
        drain("midfill_change", n);
        n = n + 1;
        checks++;
        if (ex !== 10'd1 || ey !== 9'd1) begin
            failures++;
            $display("FAIL midfill_change model first pixel (%0d,%0d) expected (1,1)", ex, ey);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        push_rect(0, 0, 1, 1);
        start_pass(0, 0, 1, 1, 1'b1);
        for (int p = 0; p < 7; p++) begin
            drain("back_to_back", n);
            check_count("back_to_back", n, 4);
            check_idle("back_to_back_gap", 1, 1);
            if (p == 6) start_i = 1'b0;
            else push_rect(0, 0, 1, 1);
            @(negedge clk);
        end
        check_idle("back_to_back_stop", 1, 1);
        repeat (3) @(negedge clk);
        check_idle("back_to_back_stop2", 1, 1);
    endtask

    task automatic test_reset_midfill();
        int  n;
        bit  saw_done;
        logic [W-1:0] ex;
        logic [H-1:0] ey;
        push_rect(0, 0, 5, 6);
        start_pass(0, 0, 5, 6, 1'b0);
        for (int i = 0; i < 10; i++) begin
            {ex, ey} = exp_q.pop_front();
            checks++;
            if (busy_o !== 1'b1 || {x_o, y_o} !== {ex, ey}) begin
                failures++;
                $display("FAIL reset_midfill pixel%0d got busy=%0b (%0d,%0d) expected (%0d,%0d)",
                         i, busy_o, x_o, y_o, ex, ey);
            end
            @(negedge clk);
        end
        exp_q.delete();
        #1 n_rst = 1'b0;
        #1 check_idle("reset_midfill_immediate", 0, 0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_o || busy_o) saw_done = 1'b1;
        end
        n_rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (done_o || busy_o) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin
            failures++;
            $display("FAIL reset_midfill activity after abort got busy/done expected none");
        end
        check_idle("reset_midfill_wait", 0, 0);
        push_rect(0, 0, 5, 6);
        start_pass(0, 0, 5, 6, 1'b0);
        drain("reset_midfill_restart", n);
        check_count("reset_midfill_restart", n, 42);
    endtask

    task automatic test_edge();
        int n;
        push_rect((1 << W) - 2, 0, (1 << W) - 1, 1);
        start_pass((1 << W) - 2, 0, (1 << W) - 1, 1, 1'b0);
        drain("x_edge", n);
        check_count("x_edge", n, 4);
        check_idle("x_edge_after", (1 << W) - 1, 1);
        push_rect(4, (1 << H) - 1, 6, (1 << H) - 2);
        start_pass(6, (1 << H) - 2, 4, (1 << H) - 1, 1'b0);
        drain("y_edge", n);
        check_count("y_edge", n, 6);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_swapped();
        test_single();
        test_lines();
        test_midfill_change();
        test_back_to_back();
        test_reset_midfill();
        test_edge();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
